// File: rtl/uart_pkg.sv
// Definitions shared by the UART transmitter and the future receiver:
// FSM states, line idle level, parity modes and the parity helper.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_e;

  localparam logic IDLE_LEVEL       = 1'b1;
  localparam logic PARITY_MODE_EVEN = 1'b0;
  localparam logic PARITY_MODE_ODD  = 1'b1;

  // Unused upper bits of a narrow word are zero, so they do not disturb the XOR.
  function automatic logic parity_of(input logic [7:0] data, input logic mode);
    return (^data) ^ mode;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Host-side handshake and serial line of the UART transmitter.
interface uart_tx_if #(
  parameter int DATA_BITS = 8
);
  logic                 tx_start;
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx;
  logic                 tx_busy;
  logic                 tx_done;

  modport master (output tx_start, tx_data, input tx, tx_busy, tx_done);
  modport slave  (input tx_start, tx_data, output tx, tx_busy, tx_done);
endinterface

// File: rtl/baud_tick_sync.sv
// Brings the asynchronous baud square wave into the clock domain and turns
// each of its rising edges into a single-cycle baud_tick_o strobe.
module baud_tick_sync (
  input  logic clock,
  input  logic reset,
  input  logic baud_clk_i,
  output logic baud_tick_o
);

  logic [1:0] sync_q;
  logic       prev_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make each flop take its pre-edge input, so this forms a real three-stage chain instead of collapsing into one flop.
      sync_q <= {sync_q[0], baud_clk_i};
      prev_q <= sync_q[1];
    end
  end

  assign baud_tick_o = sync_q[1] & ~prev_q;

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_BITS data bits LSB first, optional parity,
// STOP_BITS stop bits; every bit boundary is a synchronized baud tick.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic      clock,
  input  logic      reset,
  input  logic      baud_clk,
  uart_tx_if.slave  bus
);

  localparam logic [2:0] LAST_BIT    = 3'(DATA_BITS - 1);
  localparam logic       LAST_STOP   = 1'(STOP_BITS - 1);
  localparam logic       PARITY_MODE = (PARITY_ODD != 0) ? PARITY_MODE_ODD : PARITY_MODE_EVEN;

  uart_state_e          state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [2:0]           bit_cnt_q, bit_cnt_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic                 parity_q, parity_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 baud_tick;

  baud_tick_sync u_tick (
    .clock      (clock),
    .reset      (reset),
    .baud_clk_i (baud_clk),
    .baud_tick_o(baud_tick)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      parity_q   <= 1'b0;
      tx_q       <= IDLE_LEVEL;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      parity_q   <= parity_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    // NOTE: every next-state signal gets a default here, so no path through the case leaves one unassigned and no latch is inferred.
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    parity_d   = parity_q;
    tx_d       = tx_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        tx_d   = IDLE_LEVEL;
        busy_d = 1'b0;
        if (bus.tx_start) begin
          shift_d  = bus.tx_data;
          parity_d = parity_of(8'(bus.tx_data), PARITY_MODE);
          busy_d   = 1'b1;
          state_d  = ST_ARM;
        end
      end
      // ARM waits for a tick so the start bit always lasts a full bit time.
      ST_ARM: if (baud_tick) begin
        tx_d    = 1'b0;
        state_d = ST_START;
      end
      ST_START: if (baud_tick) begin
        tx_d      = shift_q[0];
        shift_d   = shift_q >> 1;
        bit_cnt_d = '0;
        state_d   = ST_DATA;
      end
      ST_DATA: if (baud_tick) begin
        if (bit_cnt_q == LAST_BIT) begin
          stop_cnt_d = 1'b0;
          if (PARITY_EN != 0) begin
            tx_d    = parity_q;
            state_d = ST_PARITY;
          end else begin
            tx_d    = IDLE_LEVEL;
            state_d = ST_STOP;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          tx_d      = shift_q[0];
          shift_d   = shift_q >> 1;
        end
      end
      ST_PARITY: if (baud_tick) begin
        tx_d       = IDLE_LEVEL;
        stop_cnt_d = 1'b0;
        state_d    = ST_STOP;
      end
      ST_STOP: if (baud_tick) begin
        if (stop_cnt_q == LAST_STOP) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          stop_cnt_d = stop_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.tx      = tx_q;
  assign bus.tx_busy = busy_q;
  assign bus.tx_done = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: four configurations share one stimulus stream,
// and a per-configuration monitor decodes each frame off the serial line.
module tb_uart_tx;

  logic       clock    = 1'b0;
  logic       reset    = 1'b0;
  logic       baud_clk = 1'b0;
  logic       tx_start = 1'b0;
  logic [7:0] tx_data  = 8'h00;

  int baud_half  = 160;
  int period_cyc = 16;
  bit mon_en     = 1'b0;
  int n_checks   = 0;
  int n_fail     = 0;
  int done_cnt [4];

  logic [11:0] q0[$], q1[$], q2[$], q3[$];

  uart_tx_if #(.DATA_BITS(8)) bus0 ();
  uart_tx_if #(.DATA_BITS(8)) bus1 ();
  uart_tx_if #(.DATA_BITS(8)) bus2 ();
  uart_tx_if #(.DATA_BITS(8)) bus3 ();

  assign bus0.tx_start = tx_start;
  assign bus0.tx_data  = tx_data;
  assign bus1.tx_start = tx_start;
  assign bus1.tx_data  = tx_data;
  assign bus2.tx_start = tx_start;
  assign bus2.tx_data  = tx_data;
  assign bus3.tx_start = tx_start;
  assign bus3.tx_data  = tx_data;

  logic [3:0] tx_w, busy_w, done_w;
  assign tx_w   = {bus3.tx, bus2.tx, bus1.tx, bus0.tx};
  assign busy_w = {bus3.tx_busy, bus2.tx_busy, bus1.tx_busy, bus0.tx_busy};
  assign done_w = {bus3.tx_done, bus2.tx_done, bus1.tx_done, bus0.tx_done};

  uart_tx #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut0 (
    .clock(clock), .reset(reset), .baud_clk(baud_clk), .bus(bus0));
  uart_tx #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) dut1 (
    .clock(clock), .reset(reset), .baud_clk(baud_clk), .bus(bus1));
  uart_tx #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) dut2 (
    .clock(clock), .reset(reset), .baud_clk(baud_clk), .bus(bus2));
  uart_tx #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) dut3 (
    .clock(clock), .reset(reset), .baud_clk(baud_clk), .bus(bus3));

  always #10 clock = ~clock;

  initial forever #(baud_half) baud_clk = ~baud_clk;

  always @(posedge clock)
    for (int k = 0; k < 4; k++)
      if (done_w[k]) done_cnt[k] <= done_cnt[k] + 1;

  function automatic int cfg_par_en(input int k);
    return (k == 1 || k == 2) ? 1 : 0;
  endfunction

  function automatic int cfg_odd(input int k);
    return (k == 2) ? 1 : 0;
  endfunction

  function automatic int cfg_stops(input int k);
    return (k == 3) ? 2 : 1;
  endfunction

  function automatic int frame_len(input int k);
    return 1 + 8 + cfg_par_en(k) + cfg_stops(k);
  endfunction

  // Line levels in transmit order, bit 0 first; unused positions stay 1.
  function automatic logic [11:0] build(input int k, input logic [7:0] d);
    logic [11:0] bits;
    int          n;
    int          ones;
    bits = '1;
    bits[0] = 1'b0;
    n = 1;
    ones = 0;
    for (int i = 0; i < 8; i++) begin
      bits[n] = d[i];
      ones += int'(d[i]);
      n++;
    end
    if (cfg_par_en(k) == 1) begin
      bits[n] = ((ones % 2) == 1) ^ (cfg_odd(k) == 1);
      n++;
    end
    return bits;
  endfunction

  function automatic void push_exp(input logic [7:0] d);
    q0.push_back(build(0, d));
    q1.push_back(build(1, d));
    q2.push_back(build(2, d));
    q3.push_back(build(3, d));
  endfunction

  function automatic int q_size(input int k);
    case (k)
      0:       return q0.size();
      1:       return q1.size();
      2:       return q2.size();
      default: return q3.size();
    endcase
  endfunction

  function automatic logic [11:0] q_pop(input int k);
    case (k)
      0:       return q0.pop_front();
      1:       return q1.pop_front();
      2:       return q2.pop_front();
      default: return q3.pop_front();
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic check_near(input string name, input int got, input int exp, input int tol);
    n_checks++;
    if (got < exp - tol || got > exp + tol) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d +/- %0d", name, got, exp, tol);
    end
  endtask

  task automatic mon(input int k);
    logic        prev;
    logic        cur;
    logic        busy_ok;
    logic [11:0] got;
    logic [11:0] exp;
    int          n;
    int          p;
    int          dur;
    bit          seen;
    prev = 1'b1;
    forever begin
      @(negedge clock);
      cur = tx_w[k];
      if (mon_en && !reset && prev && !cur) begin
        n = frame_len(k);
        p = period_cyc;
        check($sformatf("dut%0d_frame_expected", k), 32'(q_size(k) != 0), 32'(1));
        exp = (q_size(k) != 0) ? q_pop(k) : 12'hFFF;
        got = '1;
        dur = 0;
        repeat (p / 2) begin @(negedge clock); dur++; end
        got[0]  = tx_w[k];
        busy_ok = busy_w[k];
        for (int i = 1; i < n; i++) begin
          repeat (p) begin @(negedge clock); dur++; end
          got[i]  = tx_w[k];
          busy_ok = busy_ok & busy_w[k];
        end
        check($sformatf("dut%0d_frame_bits", k), 32'(got), 32'(exp));
        check($sformatf("dut%0d_busy_in_frame", k), 32'(busy_ok), 32'(1));
        seen = 1'b0;
        for (int j = 0; j < p + 6 && !seen; j++) begin
          @(negedge clock);
          dur++;
          if (done_w[k]) seen = 1'b1;
        end
        check($sformatf("dut%0d_done_seen", k), 32'(seen), 32'(1));
        if (seen) begin
          check_near($sformatf("dut%0d_frame_cycles", k), dur, n * p, 3);
          check($sformatf("dut%0d_busy_at_done", k), 32'(busy_w[k]), 32'(0));
          check($sformatf("dut%0d_tx_at_done", k), 32'(tx_w[k]), 32'(1));
          @(negedge clock);
          check($sformatf("dut%0d_done_single", k), 32'(done_w[k]), 32'(0));
        end
        cur = tx_w[k];
      end
      prev = cur;
    end
  endtask

  initial mon(0);
  initial mon(1);
  initial mon(2);
  initial mon(3);

  task automatic wait_idle();
    int t;
    t = 0;
    while (busy_w != 4'h0 && t < 20000) begin
      @(negedge clock);
      t++;
    end
    check("wait_idle", 32'(busy_w), 32'(0));
    repeat (4) @(negedge clock);
  endtask

  task automatic send(input logic [7:0] d, input bit push);
    @(negedge clock);
    tx_data  = d;
    tx_start = 1'b1;
    if (push) push_exp(d);
    @(negedge clock);
    check($sformatf("accept_busy_%02h", d), 32'(busy_w), 32'(4'hF));
    tx_start = 1'b0;
    tx_data  = ~d;
  endtask

  task automatic set_rate(input int half);
    baud_half  = half;
    period_cyc = 2 * half / 20;
    repeat (4 * period_cyc) @(negedge clock);
  endtask

  initial begin
    int base [4];
    int t;
    int rates [4] = '{160, 250, 330, 480};
    bit all_done;

    #2 reset = 1'b1;
    #1;
    check("reset_tx", 32'(tx_w), 32'(4'hF));
    check("reset_busy", 32'(busy_w), 32'(0));
    check("reset_done", 32'(done_w), 32'(0));
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    check("idle_tx", 32'(tx_w), 32'(4'hF));
    mon_en = 1'b1;

    // Basic frame, then a parity vector with a start pulse that must be ignored.
    set_rate(160);
    send(8'h55, 1'b1);
    wait_idle();
    send(8'hA3, 1'b1);
    repeat (5 * period_cyc) @(negedge clock);
    tx_data  = 8'h12;
    tx_start = 1'b1;
    @(negedge clock);
    tx_start = 1'b0;
    tx_data  = 8'h00;
    wait_idle();

    // Back-to-back frames with tx_start held high.
    push_exp(8'h00);
    push_exp(8'hFF);
    for (int k = 0; k < 4; k++) base[k] = done_cnt[k];
    @(negedge clock);
    tx_data  = 8'h00;
    tx_start = 1'b1;
    @(negedge clock);
    tx_data  = 8'hFF;
    t = 0;
    while (!done_w[0] && t < 5000) begin @(negedge clock); t++; end
    check("b2b_first_done", 32'(done_w[0]), 32'(1));
    @(negedge clock);
    check("b2b_rearm_busy", 32'(busy_w[0]), 32'(1));
    check("b2b_rearm_tx", 32'(tx_w[0]), 32'(1));
    t = 0;
    all_done = 1'b0;
    while (!all_done && t < 5000) begin
      @(negedge clock);
      t++;
      all_done = 1'b1;
      for (int k = 0; k < 4; k++) if (done_cnt[k] <= base[k]) all_done = 1'b0;
    end
    check("b2b_all_first_done", 32'(all_done), 32'(1));
    repeat (2) @(negedge clock);
    tx_start = 1'b0;
    wait_idle();

    // Reset in the middle of data bit 3 abandons the frame at once.
    mon_en = 1'b0;
    send(8'h5A, 1'b0);
    t = 0;
    while (tx_w[0] && t < 2 * period_cyc + 10) begin @(negedge clock); t++; end
    check("rst_frame_started", 32'(tx_w[0]), 32'(0));
    repeat (4 * period_cyc + period_cyc / 2) @(negedge clock);
    #3 reset = 1'b1;
    #1;
    check("rst_async_tx", 32'(tx_w), 32'(4'hF));
    check("rst_async_busy", 32'(busy_w), 32'(0));
    repeat (3) @(negedge clock);
    check("rst_hold_done", 32'(done_w), 32'(0));
    reset = 1'b0;
    repeat (3) @(negedge clock);
    mon_en = 1'b1;
    send(8'hC6, 1'b1);
    wait_idle();

    // Rate sweep: bit widths must follow each baud period.
    for (int r = 0; r < 4; r++) begin
      set_rate(rates[r]);
      send(8'h3C, 1'b1);
      wait_idle();
    end

    repeat (200) @(negedge clock);
    for (int k = 0; k < 4; k++)
      check($sformatf("dut%0d_queue_empty", k), 32'(q_size(k)), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1800000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial UART transmitter; the stage directly downstream of the baud generator. It consumes the generator's `baud_clk` square wave and converts a parallel byte into an asynchronous serial frame on `tx`, LSB first. The frame is a start bit, data bits, optional parity, then stop bits. A start/busy/done handshake lets a host or FIFO feed it one word at a time.

## Interface
- `DATA_BITS`, default 8: data bits per frame; legal range 5–8.
- `PARITY_EN`, default 0: 1 inserts a parity bit after the data bits.
- `PARITY_ODD`, default 0: 0 selects even parity, 1 selects odd; ignored when `PARITY_EN`=0.
- `STOP_BITS`, default 1: stop bits per frame, 1 or 2.
- `clock` in 1: system clock, 50 MHz; all state is on its rising edge.
- `reset` in 1: asynchronous, active-high; clears all state immediately.
- `baud_clk` in 1: baud generator output, asynchronous to `clock`. One period equals one bit time.
- `tx_start` in 1: request to send `tx_data`; sampled every `clock` edge.
- `tx_data` in DATA_BITS: word to send; captured in the accept cycle only.
- `tx` out 1: serial line; idles at 1.
- `tx_busy` out 1: high from the accept edge until frame end.
- `tx_done` out 1: one-`clock` pulse at frame completion.

## Operation
- **Tick generation.** `baud_clk` passes through a 2-flop synchronizer. A rising-edge detector on the synchronized value produces `baud_tick`, a single-cycle strobe. Every bit boundary occurs on a `baud_tick`.
- **States:** IDLE, ARM, START, DATA, PARITY, STOP.
- **IDLE:**
  - `tx`=1, `tx_busy`=0.
  - If `tx_start`=1: capture `tx_data` into the shift register, compute parity from the captured data, set `tx_busy`=1, and go to ARM.
- **ARM:** `tx` stays 1. On `baud_tick`: `tx`←0 and go to START. ARM exists so the start bit is always a full bit time.
- **START:** on `baud_tick`: `tx`←shift[0], shift right, `bit_cnt`←0, go to DATA.
- **DATA:** on `baud_tick`:
  - If `bit_cnt`=DATA_BITS−1: go to PARITY with `tx`←parity bit when `PARITY_EN`=1; otherwise go to STOP with `tx`←1.
  - Otherwise: `bit_cnt`+1, `tx`←next bit.
- **PARITY:** on `baud_tick`: `tx`←1, go to STOP.
  - Even parity: parity bit = XOR of the data bits.
  - Odd parity: the inverse of that XOR.
- **STOP:**
  - `stop_cnt` counts ticks.
  - On the tick that ends the last stop bit: go to IDLE, set `tx_busy`←0, and pulse `tx_done`=1 for one cycle.
- **`tx_start` while not IDLE:** ignored; no queuing, no captured data change.
- **`tx_start` in the `tx_done` cycle:** accepted, because the state is already IDLE. Back-to-back frames therefore have no idle gap beyond the ARM alignment.
- **`tx_data` changes after accept:** no effect on the frame in flight.
- **`baud_clk` stops:** the FSM holds its current state and `tx` level indefinitely; there is no timeout.
- **`baud_rate` changes mid-frame:** the remaining bits use the new period. This is allowed and is not an error.
- **Reset mid-frame:** `tx`=1 asynchronously, FSM returns to IDLE, all counters clear, and the partial frame is abandoned.
- **Reset values:** `tx`=1, `tx_busy`=0, `tx_done`=0, state IDLE, synchronizer flops 0.

## Timing
- **Tick latency:** a `baud_clk` rising edge produces `baud_tick` 2–3 `clock` cycles later, depending on synchronizer phase.
- **Accept:** `tx_busy` goes high on the same edge that samples `tx_start`=1 in IDLE.
- **Start bit:** `tx` falls on the `clock` edge where the first `baud_tick` after accept is seen.
- **Bit time:** each bit occupies exactly one `baud_tick` interval.
- **Frame length:** 1 + DATA_BITS + PARITY_EN + STOP_BITS tick intervals, measured from the `tx` falling edge.
- **Completion:** `tx_done` and `tx_busy`=0 take effect on the edge that ends the last stop bit. `tx` is already 1 and remains 1.
- **Registered outputs:** all outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- **Shared package `uart_pkg`:**
  - the FSM state enum (shared with the future `uart_rx`);
  - the `IDLE_LEVEL`=1 constant;
  - the parity-mode constants.
- **Sub-module `baud_tick_sync`:** 2-flop synchronizer plus rising-edge detect producing `baud_tick`. It is reused by `uart_rx`.
- **Top level:** the FSM, the shift register, `bit_cnt` (3-bit), `stop_cnt` (1-bit), and the parity register.

## Test plan
- **Basic frame:** defaults, `tx_data`=0x55, one `tx_start` pulse → `tx` shows 0, 1,0,1,0,1,0,1,0, 1, each bit exactly one `baud_clk` period; `tx_done` pulses once; `tx_busy` high for 10 bit periods plus the ARM interval.
- **Even parity:** `PARITY_EN`=1, `PARITY_ODD`=0, data 0xA3 → data bits 1,1,0,0,0,1,0,1 then parity 0; with `PARITY_ODD`=1 the parity bit is 1. Frame is 11 bits.
- **Back-to-back with ignored start:**
  - Hold `tx_start`=1 continuously with data 0x00 then 0xFF → two frames. The second frame's ARM begins in the cycle after `tx_done`.
  - A `tx_start` pulse mid-frame with 0x12 is ignored; the frame bits are unchanged.
- **Reset mid-frame:** assert `reset` during data bit 3 → `tx`=1 and `tx_busy`=0 immediately without waiting for a `clock` edge. After release the next frame is correct.
- **Baud rate sweep:** step `baud_rate` through 0–3, sending 0x3C at each rate → bit widths match the `baud_clk` period for that rate within 3 `clock` cycles. Also set `STOP_BITS`=2 and check the stop level lasts 2 periods.
